// File: rtl/chinx_intc_pkg.sv
// Shared types and constants for the chinx interrupt controller.
package chinx_intc_pkg;

   // Handshake sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } intc_state_t;

   // Default number of interrupt sources.
   localparam int NSRC_DEFAULT = 8;

   // Source index wired to the system tick.
   localparam int TICK_SRC = 0;

endpackage : chinx_intc_pkg

// File: rtl/chinx_intc_prio.sv
// Lowest-index-wins priority encoder over a request vector.
module chinx_intc_prio #(
   parameter int NSRC = 8,
   parameter int IDW  = $clog2(NSRC)
) (
   input  logic [NSRC-1:0] req_i,
   output logic            any_o,
   output logic [IDW-1:0]  id_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      any_o = |req_i;
      id_o  = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = IDW'(i);
      end
   end

endmodule : chinx_intc_prio

// File: rtl/chinx_intc.sv
// Toggle-encoded interrupt controller: edge detect, pending/overrun tracking,
// per-source mask and a one-at-a-time irq/ack handshake to the core.
module chinx_intc
   import chinx_intc_pkg::*;
#(
   parameter int NSRC = NSRC_DEFAULT,
   parameter int IDW  = $clog2(NSRC)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] ireq,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wdata,
   output logic [NSRC-1:0] mask,
   output logic [NSRC-1:0] pending,
   output logic [NSRC-1:0] ovf,
   input  logic [NSRC-1:0] ovf_clr,
   output logic            irq,
   output logic [IDW-1:0]  irq_id,
   input  logic            ack
);

   logic [NSRC-1:0] ireq_q;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] ovf_q, ovf_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic            irq_q, irq_d;
   logic [IDW-1:0]  irq_id_q, irq_id_d;
   intc_state_t     state_q, state_d;

   logic [NSRC-1:0] evt;
   logic [NSRC-1:0] ack_clr;
   logic            take_ack;
   logic            prio_any;
   logic [IDW-1:0]  prio_id;

   assign evt = ireq ^ ireq_q;

   chinx_intc_prio #(
      .NSRC (NSRC),
      .IDW  (IDW)
   ) u_prio (
      .req_i (pending_q & ~mask_q),
      .any_o (prio_any),
      .id_o  (prio_id)
   );

   // Handshake sequencer: pick a source in IDLE, hold it until ack, then one quiet cycle.
   always_comb begin
      state_d  = state_q;
      irq_d    = irq_q;
      irq_id_d = irq_id_q;
      take_ack = 1'b0;
      case (state_q)
         IDLE: begin
            if (prio_any) begin
               irq_d    = 1'b1;
               irq_id_d = prio_id;
               state_d  = PRESENT;
            end
         end
         PRESENT: begin
            if (ack) begin
               take_ack = 1'b1;
               irq_d    = 1'b0;
               state_d  = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pending, overrun and mask next state; a same-cycle event beats an ack clear,
   // and a same-cycle overrun beats a write-one-to-clear.
   always_comb begin
      ack_clr   = take_ack ? (NSRC'(1) << irq_id_q) : '0;
      pending_d = (pending_q & ~ack_clr) | evt;
      ovf_d     = (ovf_q & ~ovf_clr) | (evt & pending_q & ~ack_clr);
      mask_d    = mask_we ? mask_wdata : mask_q;
   end

   // State registers with synchronous reset; ireq_q tracks the input even in reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         ireq_q    <= ireq;
         pending_q <= '0;
         ovf_q     <= '0;
         mask_q    <= '1;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
         state_q   <= IDLE;
      end else begin
         ireq_q    <= ireq;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         mask_q    <= mask_d;
         irq_q     <= irq_d;
         irq_id_q  <= irq_id_d;
         state_q   <= state_d;
      end
   end

   assign mask    = mask_q;
   assign pending = pending_q;
   assign ovf     = ovf_q;
   assign irq     = irq_q;
   assign irq_id  = irq_id_q;

endmodule : chinx_intc

// File: tb/tb_chinx_intc.sv
// Directed self-checking bench for chinx_intc.
module tb_chinx_intc;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ireq;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] mask;
   logic [7:0] pending;
   logic [7:0] ovf;
   logic [7:0] ovf_clr;
   logic       irq;
   logic [2:0] irq_id;
   logic       ack;

   int n_tests = 0;
   int n_fail  = 0;

   chinx_intc #(.NSRC(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ireq       (ireq),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .mask       (mask),
      .pending    (pending),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr),
      .irq        (irq),
      .irq_id     (irq_id),
      .ack        (ack)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle; inputs set afterwards are seen at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; ireq = 8'h01; mask_we = 1'b0; mask_wdata = 8'h00;
      ovf_clr = 8'h00; ack = 1'b0;

      // Reset with source 0 held high.
      tick(); tick(); tick();
      check("rst_irq", irq, 1'b0);
      check("rst_id", irq_id, 3'd0);
      check("rst_pending", pending, 8'h00);
      check("rst_ovf", ovf, 8'h00);
      check("rst_mask", mask, 8'hFF);
      rst = 1'b0;
      mask_we = 1'b1; mask_wdata = 8'h00;
      tick();
      mask_we = 1'b0;
      check("mask_clear", mask, 8'h00);
      tick(); tick(); tick();
      check("no_spurious_irq", irq, 1'b0);
      check("no_spurious_pend", pending, 8'h00);

      // Single source 3: pending after one edge, irq after two.
      ireq = 8'h09;
      tick();
      check("s3_pending", pending, 8'h08);
      check("s3_irq_early", irq, 1'b0);
      tick();
      check("s3_irq", irq, 1'b1);
      check("s3_id", irq_id, 3'd3);
      tick(); tick();
      check("s3_hold_irq", irq, 1'b1);
      check("s3_hold_id", irq_id, 3'd3);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("s3_ack_irq", irq, 1'b0);
      check("s3_ack_pend", pending, 8'h00);
      tick(); tick();
      check("s3_idle", irq, 1'b0);

      // Sources 5 and 2 together: 2 wins, then 5 after the gap.
      ireq = 8'h2D;
      tick();
      check("p25_pending", pending, 8'h24);
      tick();
      check("p25_irq1", irq, 1'b1);
      check("p25_id1", irq_id, 3'd2);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("p25_ack_irq", irq, 1'b0);
      check("p25_ack_pend", pending, 8'h20);
      tick();
      check("p25_gap", irq, 1'b0);
      tick();
      check("p25_irq2", irq, 1'b1);
      check("p25_id2", irq_id, 3'd5);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("p25_done_pend", pending, 8'h00);
      tick(); tick();

      // Source 1 toggled twice without ack: overrun, one presentation.
      ireq = 8'h2F;
      tick();
      check("ov_pend", pending, 8'h02);
      check("ov_ovf0", ovf, 8'h00);
      tick();
      check("ov_irq", irq, 1'b1);
      check("ov_id", irq_id, 3'd1);
      tick();
      ireq = 8'h2D;
      tick();
      check("ov_ovf", ovf, 8'h02);
      check("ov_still_id", irq_id, 3'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ov_ack_pend", pending, 8'h00);
      check("ov_sticky", ovf, 8'h02);
      tick(); tick(); tick();
      check("ov_single_pres", irq, 1'b0);
      ovf_clr = 8'h02;
      tick();
      ovf_clr = 8'h00;
      check("ov_clr", ovf, 8'h00);

      // Ack of source 4 coincides with a new toggle of source 4.
      ireq = 8'h3D;
      tick();
      check("ae_pend", pending, 8'h10);
      tick();
      check("ae_irq", irq, 1'b1);
      check("ae_id", irq_id, 3'd4);
      ack = 1'b1; ireq = 8'h2D;
      tick();
      ack = 1'b0;
      check("ae_irq_low", irq, 1'b0);
      check("ae_pend_kept", pending, 8'h10);
      check("ae_no_ovf", ovf, 8'h00);
      tick();
      check("ae_gap", irq, 1'b0);
      tick();
      check("ae_repres", irq, 1'b1);
      check("ae_repres_id", irq_id, 3'd4);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ae_done_pend", pending, 8'h00);
      tick(); tick();

      // Masked source 6 latches pending but is not presented until unmasked.
      mask_we = 1'b1; mask_wdata = 8'h40;
      tick();
      mask_we = 1'b0;
      check("m6_mask", mask, 8'h40);
      ireq = 8'h6D;
      tick();
      check("m6_pend", pending, 8'h40);
      tick(); tick();
      check("m6_no_irq", irq, 1'b0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("m6_stray_ack_pend", pending, 8'h40);
      check("m6_stray_ack_irq", irq, 1'b0);
      mask_we = 1'b1; mask_wdata = 8'h00;
      tick();
      mask_we = 1'b0;
      check("m6_unmask_irq0", irq, 1'b0);
      tick();
      check("m6_irq", irq, 1'b1);
      check("m6_id", irq_id, 3'd6);
      mask_we = 1'b1; mask_wdata = 8'hFF;
      tick();
      mask_we = 1'b0;
      check("m6_remask_hold", irq, 1'b1);
      check("m6_remask_id", irq_id, 3'd6);

      // Reset mid-handshake.
      rst = 1'b1;
      tick();
      check("mr_irq", irq, 1'b0);
      check("mr_pend", pending, 8'h00);
      check("mr_mask", mask, 8'hFF);
      check("mr_id", irq_id, 3'd0);
      rst = 1'b0;
      tick(); tick();
      check("mr_quiet", irq, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_chinx_intc

// File: doc/chinx_intc.md
# chinx_intc

Interrupt controller that receives toggle-encoded interrupt requests and presents one request at a time to the CPU core. Each source, such as the system tick, signals one event by inverting its `ireq` level. The controller detects each inversion, latches it as pending, applies a per-source mask, and holds the lowest-numbered unmasked pending source on an `irq`/`ack` handshake until the core acknowledges it. It sits between the peripheral/timer blocks and the core's exception logic.

## Interface
Parameters:
- `NSRC`, 8: number of interrupt sources (2–32).
- `IDW`, `$clog2(NSRC)`: width of the source index.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `ireq`  in  NSRC: toggle-encoded request per source; every level change is one event.
- `mask_we`  in  1: write strobe for the mask register.
- `mask_wdata`  in  NSRC: new mask value; 1 = source masked.
- `mask`  out  NSRC: current mask register.
- `pending`  out  NSRC: current pending bits.
- `ovf`  out  NSRC: sticky overrun flags.
- `ovf_clr`  in  NSRC: write-one-to-clear for `ovf`; single-cycle pulse per bit.
- `irq`  out  1: interrupt presented to the core.
- `irq_id`  out  IDW: index of the presented source; valid while `irq`=1.
- `ack`  in  1: core has taken the presented interrupt; sampled only while `irq`=1.

## Operation
- Edge detect: `ireq_q` holds the previous sample. `evt[i] = ireq[i] ^ ireq_q[i]`.
- During reset, `ireq_q <= ireq`, so a source that is high at reset does not produce a spurious event.
- Pending:
  - `evt[i]` sets `pending[i]`. Masked sources still latch pending.
  - If `evt[i]` arrives while `pending[i]` is already 1 and no clear is happening that cycle, set `ovf[i]`.
- Ack clear: an accepted ack clears `pending[irq_id]`.
  - If `evt` for the same source occurs in the same cycle, the event wins: pending stays 1 and `ovf` is unchanged.
- `ovf` clear:
  - `ovf_clr[i]` clears `ovf[i]`.
  - If an overrun on source i occurs in the same cycle, the set wins.
- Mask: `mask_we` loads `mask <= mask_wdata` at the next edge.
- FSM (states IDLE, PRESENT, GAP):
  - IDLE: if `|(pending & ~mask)`, register `irq_id` = lowest set index, `irq <= 1`, go to PRESENT.
  - PRESENT: `irq`=1 and `irq_id` frozen. Mask writes and new events do not alter or withdraw the presentation. When `ack`=1: clear the pending bit, `irq <= 0`, go to GAP.
  - GAP: one idle cycle with `irq`=0, then go to IDLE. This gives the core one cycle of `irq` low between back-to-back interrupts.
- Priority: the lowest index wins. It is evaluated only in IDLE.
- Reset values: `irq`=0, `irq_id`=0, `pending`=0, `ovf`=0, `mask`=all ones (all masked), FSM in IDLE.
- Reset asserted mid-handshake drops `irq` at the next edge and discards all pending events.

## Timing
- Source toggle sampled at edge k → `pending` set after edge k → `irq`=1 after edge k+1. Latency from `ireq` change to `irq` is 2 cycles.
- `ack` sampled at edge m (in PRESENT) → `irq`=0 and `pending` bit cleared after edge m.
- GAP occupies edge m+1. The earliest next `irq`=1 is after edge m+2.
- `irq_id` stays stable from the rise of `irq` through the `ack` edge.
- `mask_we` at edge k takes effect for arbitration at edge k+1.
- A masked source that is unmasked while pending is presented 1 cycle after the mask write, if the FSM is in IDLE.
- `ack` while `irq`=0 is ignored.

## Structure
- Package `chinx_intc_pkg` holds:
  - `intc_state_t` enum (IDLE, PRESENT, GAP);
  - default `NSRC` constant;
  - `TICK_SRC` = 0, the source index of the system tick.
- Sub-module `chinx_intc_prio`: combinational lowest-index priority encoder, parameterized by `NSRC`. Outputs `any` and `id`.
- Top module holds `ireq_q`, `pending`, `ovf`, `mask`, the FSM and the output registers.

## Test plan
- Reset with `ireq`=8'h01 held high, then write mask=8'h00 → no `irq` ever; `pending`=0.
- With mask=0, toggle `ireq[3]` at cycle 10 → `pending[3]` set at 11, `irq`=1 with `irq_id`=3 at 12; `ack` at 15 → `irq`=0 and `pending`=0 at 16.
- Toggle sources 5 and 2 in the same cycle → `irq_id`=2 first. After `ack`, `irq` is low for exactly one GAP cycle, then `irq_id`=5.
- Toggle `ireq[1]` twice, 3 cycles apart, with no ack → `ovf[1]`=1, only one presentation; `ovf_clr[1]` pulse → `ovf[1]`=0.
- `ack` for id 4 in the same cycle as a new `ireq[4]` toggle → `pending[4]` stays 1, `ovf[4]`=0, and id 4 is re-presented after GAP.
- Mask source 6 and toggle it → `pending[6]`=1, no `irq`. Unmask → `irq`=1 with `irq_id`=6 one cycle later. Assert `rst` while `irq`=1 → next edge `irq`=0, `pending`=0, `mask`=8'hFF.
